// File: rtl/cluster_pass_scheduler_pkg.sv
// Shared cluster-finding definitions: scheduler state encoding, pass limit
// and priority-encoder latency.
package cluster_pass_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } sched_state_t;

    localparam int MXPASSES_DEFAULT    = 4;
    localparam int MXPASSES_LIMIT      = 8;
    localparam int PRI_LATENCY_DEFAULT = 2;

    localparam int CNT_BITS      = 3;
    localparam int PASS_TAG_BITS = 3;
    localparam int PASS_CNT_BITS = 4;
    localparam int LAT_CNT_BITS  = 4;

endpackage

// File: rtl/cluster_pass_scheduler_priority.sv
// Lowest-address priority encoder over a pad mask, pipelined so the result
// (hit flag, address, cluster size, pass tag) appears LATENCY edges after issue.
module priority_n
    import cluster_pass_scheduler_pkg::*;
#(
    parameter int MXKEYS    = 192,
    parameter int MXKEYBITS = 8,
    parameter int LATENCY   = PRI_LATENCY_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       issue_i,
    input  logic [MXKEYS-1:0]          mask_i,
    input  logic [MXKEYS*CNT_BITS-1:0] cnts_i,
    input  logic [PASS_TAG_BITS-1:0]   tag_i,
    output logic                       vpf_o,
    output logic [MXKEYBITS-1:0]       adr_o,
    output logic [CNT_BITS-1:0]        cnt_o,
    output logic [PASS_TAG_BITS-1:0]   tag_o
);

    logic                     found;
    int                       sel;
    logic [MXKEYBITS-1:0]     adr_c;
    logic [CNT_BITS-1:0]      cnt_c;

    logic [LATENCY-1:0]       vpf_pipe;
    logic [MXKEYBITS-1:0]     adr_pipe [LATENCY];
    logic [CNT_BITS-1:0]      cnt_pipe [LATENCY];
    logic [PASS_TAG_BITS-1:0] tag_pipe [LATENCY];

    // Scan downwards so the lowest set pad is the last one to win.
    always_comb begin
        found = 1'b0;
        sel   = 0;
        for (int i = MXKEYS - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                found = 1'b1;
                sel   = i;
            end
        end
        adr_c = MXKEYBITS'(sel);
        cnt_c = cnts_i[sel*CNT_BITS +: CNT_BITS];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vpf_pipe <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                adr_pipe[s] <= '0;
                cnt_pipe[s] <= '0;
                tag_pipe[s] <= '0;
            end
        end else begin
            vpf_pipe[0] <= issue_i & found;
            adr_pipe[0] <= adr_c;
            cnt_pipe[0] <= cnt_c;
            tag_pipe[0] <= tag_i;
            for (int s = 1; s < LATENCY; s++) begin
                vpf_pipe[s] <= vpf_pipe[s-1];
                adr_pipe[s] <= adr_pipe[s-1];
                cnt_pipe[s] <= cnt_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign vpf_o = vpf_pipe[LATENCY-1];
    assign adr_o = adr_pipe[LATENCY-1];
    assign cnt_o = cnt_pipe[LATENCY-1];
    assign tag_o = tag_pipe[LATENCY-1];

endmodule

// File: rtl/cluster_pass_scheduler.sv
// Frame-level scheduler: repeatedly asks the priority encoder for the lowest
// valid pad, emits it as a cluster and removes it, up to MXPASSES per frame.
module cluster_pass_scheduler
    import cluster_pass_scheduler_pkg::*;
#(
    parameter int MXKEYS      = 192,
    parameter int MXKEYBITS   = 8,
    parameter int MXPASSES    = MXPASSES_DEFAULT,
    parameter int PRI_LATENCY = PRI_LATENCY_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start_i,
    input  logic [MXKEYS-1:0]          vpfs_i,
    input  logic [MXKEYS*CNT_BITS-1:0] cnts_i,
    output logic                       clu_valid_o,
    output logic [MXKEYBITS-1:0]       clu_adr_o,
    output logic [CNT_BITS-1:0]        clu_cnt_o,
    output logic [PASS_TAG_BITS-1:0]   clu_pass_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       overflow_o,
    output logic                       drop_o
);

    localparam logic [LAT_CNT_BITS-1:0]  LAT_LAST  = LAT_CNT_BITS'(PRI_LATENCY - 2);
    localparam logic [PASS_CNT_BITS-1:0] PASS_LAST = PASS_CNT_BITS'(MXPASSES);

    sched_state_t              state_q, state_d;
    logic [MXKEYS-1:0]          mask_q, mask_d;
    logic [MXKEYS*CNT_BITS-1:0] cnts_q;
    logic                       cnts_load;
    logic [PASS_CNT_BITS-1:0]   pass_q, pass_d;
    logic [LAT_CNT_BITS-1:0]    lat_q, lat_d;
    logic                       ovf_q, ovf_d;
    logic                       issue;
    logic                       clu_valid_d;

    logic                       res_vpf;
    logic [MXKEYBITS-1:0]       res_adr;
    logic [CNT_BITS-1:0]        res_cnt;
    logic [PASS_TAG_BITS-1:0]   res_tag;
    logic                       res_hit;

    priority_n #(
        .MXKEYS    (MXKEYS),
        .MXKEYBITS (MXKEYBITS),
        .LATENCY   (PRI_LATENCY)
    ) u_priority (
        .clock   (clock),
        .reset   (reset),
        .issue_i (issue),
        .mask_i  (mask_q),
        .cnts_i  (cnts_q),
        .tag_i   (pass_q[PASS_TAG_BITS-1:0]),
        .vpf_o   (res_vpf),
        .adr_o   (res_adr),
        .cnt_o   (res_cnt),
        .tag_o   (res_tag)
    );

    // An address beyond the pad range cannot be a real pad, so it counts as no hit.
    assign res_hit = res_vpf && (32'(res_adr) < MXKEYS);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cnts_load   = 1'b0;
        pass_d      = pass_q;
        lat_d       = lat_q;
        ovf_d       = ovf_q;
        issue       = 1'b0;
        clu_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mask_d    = vpfs_i;
                    cnts_load = 1'b1;
                    pass_d    = '0;
                    lat_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue   = 1'b1;
                lat_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == LAT_LAST) state_d = ST_CAPTURE;
                else                   lat_d   = lat_q + 1'b1;
            end
            ST_CAPTURE: begin
                // A stale pass tag means the pipeline lost sync; abandon as overflow.
                if (res_tag != pass_q[PASS_TAG_BITS-1:0]) begin
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (!res_hit) begin
                    ovf_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    clu_valid_d     = 1'b1;
                    mask_d[res_adr] = 1'b0;
                    pass_d          = pass_q + 1'b1;
                    if (pass_d == PASS_LAST || mask_d == '0) begin
                        ovf_d   = |mask_d;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            cnts_q      <= '0;
            pass_q      <= '0;
            lat_q       <= '0;
            ovf_q       <= 1'b0;
            clu_valid_o <= 1'b0;
            clu_adr_o   <= '0;
            clu_cnt_o   <= '0;
            clu_pass_o  <= '0;
            drop_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            pass_q      <= pass_d;
            lat_q       <= lat_d;
            ovf_q       <= ovf_d;
            clu_valid_o <= clu_valid_d;
            drop_o      <= start_i && (state_q != ST_IDLE);
            if (cnts_load) cnts_q <= cnts_i;
            if (clu_valid_d) begin
                clu_adr_o  <= res_adr;
                clu_cnt_o  <= res_cnt;
                clu_pass_o <= pass_q[PASS_TAG_BITS-1:0];
            end
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign overflow_o = (state_q == ST_DONE) && ovf_q;

endmodule
